// File: rtl/comparador_secuencia_if.sv
// Symbol-stream bus between the input/debounce stage and the code checker.
// The master drives symbols; the slave reports readiness, verdicts and lockout status.
interface comparador_secuencia_if;
    logic [1:0] sym_in;
    logic       sym_valid;
    logic       clear;
    logic       ready;
    logic       ok;
    logic       fail;
    logic       locked;
    logic [1:0] step;

    modport master (
        output sym_in, sym_valid, clear,
        input  ready, ok, fail, locked, step
    );

    modport slave (
        input  sym_in, sym_valid, clear,
        output ready, ok, fail, locked, step
    );
endinterface

// File: rtl/comparador_secuencia.sv
// Sequential 4-symbol code checker built around one shared 2-bit comparator.
// Define SECUENCIA_LOCKOUT_EN to build the fail counter, lock timer and LOCK state.

module comparador_2bits (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       salida
);
    assign salida = (a == b);
endmodule

// state    | meaning
// WAIT     | accepting symbols, step = index of next expected symbol
// RESULT   | one-cycle verdict pulse (ok or fail)
// LOCK     | input blocked after MAX_FAIL consecutive failures
module comparador_secuencia #(
    parameter logic [7:0] CODE        = 8'b11_10_01_00,
    parameter int         MAX_FAIL    = 3,
    parameter int         LOCK_CYCLES = 16
) (
    input logic                     clk,
    input logic                     rst,
    comparador_secuencia_if.slave   bus
);
    localparam logic [1:0] S_WAIT   = 2'd0;
    localparam logic [1:0] S_RESULT = 2'd1;
`ifdef SECUENCIA_LOCKOUT_EN
    localparam logic [1:0] S_LOCK   = 2'd2;
    localparam int         FW       = $clog2(MAX_FAIL + 1);
    localparam int         LW       = $clog2(LOCK_CYCLES + 1);
`endif

    if (MAX_FAIL < 1 || LOCK_CYCLES < 1) begin : g_param_check
        $error("comparador_secuencia: MAX_FAIL and LOCK_CYCLES must be >= 1");
    end

    logic [1:0] state_q, state_d;
    logic [1:0] step_q, step_d;
    logic       err_q, err_d;
    logic [1:0] code_sym;
    logic       salida;

`ifdef SECUENCIA_LOCKOUT_EN
    logic [FW-1:0] fail_cnt_q, fail_cnt_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
`endif

    assign code_sym = CODE[{step_q, 1'b0} +: 2];

    comparador_2bits u_cmp (
        .a      (bus.sym_in),
        .b      (code_sym),
        .salida (salida)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        err_d   = err_q;
`ifdef SECUENCIA_LOCKOUT_EN
        fail_cnt_d = fail_cnt_q;
        lock_cnt_d = lock_cnt_q;
`endif
        case (state_q)
            S_WAIT: begin
                if (bus.clear) begin
                    step_d = 2'd0;
                    err_d  = 1'b0;
                end else if (bus.sym_valid) begin
                    if (!salida) begin
                        err_d = 1'b1;
                    end
                    if (step_q == 2'd3) begin
                        step_d  = 2'd0;
                        state_d = S_RESULT;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
            end
            S_RESULT: begin
                err_d   = 1'b0;
                state_d = S_WAIT;
`ifdef SECUENCIA_LOCKOUT_EN
                if (!err_q) begin
                    fail_cnt_d = '0;
                end else begin
                    if (fail_cnt_q != FW'(MAX_FAIL)) begin
                        fail_cnt_d = fail_cnt_q + FW'(1);
                    end
                    // This failure is the one that reaches MAX_FAIL.
                    if (fail_cnt_q >= FW'(MAX_FAIL - 1)) begin
                        state_d    = S_LOCK;
                        lock_cnt_d = LW'(LOCK_CYCLES - 1);
                    end
                end
`endif
            end
`ifdef SECUENCIA_LOCKOUT_EN
            S_LOCK: begin
                if (lock_cnt_q == '0) begin
                    state_d    = S_WAIT;
                    fail_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q - LW'(1);
                end
            end
`endif
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_WAIT;
            step_q  <= 2'd0;
            err_q   <= 1'b0;
`ifdef SECUENCIA_LOCKOUT_EN
            fail_cnt_q <= '0;
            lock_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            err_q   <= err_d;
`ifdef SECUENCIA_LOCKOUT_EN
            fail_cnt_q <= fail_cnt_d;
            lock_cnt_q <= lock_cnt_d;
`endif
        end
    end

    // Outputs decode registered state only, so no input reaches them combinationally.
    assign bus.ready = (state_q == S_WAIT);
    assign bus.ok    = (state_q == S_RESULT) && !err_q;
    assign bus.fail  = (state_q == S_RESULT) && err_q;
    assign bus.step  = step_q;
`ifdef SECUENCIA_LOCKOUT_EN
    assign bus.locked = (state_q == S_LOCK);
`else
    assign bus.locked = 1'b0;
`endif
endmodule

// File: tb/tb_comparador_secuencia.sv
// Scoreboard bench for comparador_secuencia: stimulus pushes expected verdicts,
// a negedge monitor pops and compares them whenever ok or fail pulses.
module tb_comparador_secuencia;
    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;
    bit   exp_q[$];

    always #5 clk = ~clk;

    comparador_secuencia_if bus ();

    comparador_secuencia dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (bus.ok || bus.fail)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, bus.ok, bus.fail}, 32'd0);
            end else begin
                bit e;
                e = exp_q.pop_front();
                check("verdict", {30'd0, bus.ok, bus.fail}, e ? 32'd2 : 32'd1);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_sym(input logic [1:0] s, input bit clr);
        wait_ready();
        bus.sym_in    = s;
        bus.sym_valid = 1'b1;
        bus.clear     = clr;
        @(posedge clk); #1;
        bus.sym_valid = 1'b0;
        bus.clear     = 1'b0;
    endtask

    // seq holds symbol k in bits [2k+1:2k]; symbol 0 is sent first.
    task automatic send_seq(input logic [7:0] seq, input int gap, input bit exp_ok, input bit exp_lock);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) repeat (gap) begin @(posedge clk); #1; end
            if (k == 3) exp_q.push_back(exp_ok);
            send_sym(seq[2*k +: 2], 1'b0);
            if (k < 3) begin
                check("step_advance", {30'd0, bus.step}, k + 1);
            end else begin
                check("result_ready_low", {31'd0, bus.ready}, 32'd0);
                check("result_step_zero", {30'd0, bus.step}, 32'd0);
            end
        end
        @(posedge clk); #1;
        check("pulse_seen", exp_q.size(), 32'd0);
        if (exp_lock) begin
            check("lock_entered", {31'd0, bus.locked}, 32'd1);
        end else begin
            check("ready_back", {31'd0, bus.ready}, 32'd1);
            check("not_locked", {31'd0, bus.locked}, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sym_in    = 2'd0;
        bus.sym_valid = 1'b0;
        bus.clear     = 1'b0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_ready",  {31'd0, bus.ready},  32'd1);
        check("rst_ok",     {31'd0, bus.ok},     32'd0);
        check("rst_fail",   {31'd0, bus.fail},   32'd0);
        check("rst_locked", {31'd0, bus.locked}, 32'd0);
        check("rst_step",   {30'd0, bus.step},   32'd0);

        send_seq(8'b11_10_01_00, 0, 1'b1, 1'b0);   // 0,1,2,3 back-to-back
        send_seq(8'b11_10_11_00, 2, 1'b0, 1'b0);   // 0,3,2,3 with gaps
        send_seq(8'b00_10_01_00, 1, 1'b0, 1'b0);   // last symbol wrong
        send_seq(8'b11_10_01_11, 0, 1'b0, 1'b0);   // first symbol wrong
        send_seq(8'b11_10_01_00, 3, 1'b1, 1'b0);   // correct after failures

        // clear drops the simultaneous symbol and restarts the sequence
        send_sym(2'd0, 1'b0);
        send_sym(2'd1, 1'b0);
        check("pre_clear_step", {30'd0, bus.step}, 32'd2);
        send_sym(2'd2, 1'b1);
        check("clear_step", {30'd0, bus.step}, 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        check("clear_no_pulse", exp_q.size(), 32'd0);
        send_seq(8'b11_10_01_00, 0, 1'b1, 1'b0);

        // reset mid-sequence
        send_sym(2'd0, 1'b0);
        send_sym(2'd1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("midseq_rst_step", {30'd0, bus.step}, 32'd0);
        send_seq(8'b11_10_01_00, 0, 1'b1, 1'b0);

`ifdef SECUENCIA_LOCKOUT_EN
        send_seq(8'b11_10_01_01, 0, 1'b0, 1'b0);
        send_seq(8'b11_10_01_01, 0, 1'b0, 1'b0);
        send_seq(8'b11_10_01_01, 0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            check("lock_window", {30'd0, bus.locked, bus.ready}, 32'd2);
            bus.sym_in    = 2'd0;
            bus.sym_valid = (i % 3 == 1);
            @(posedge clk); #1;
        end
        bus.sym_valid = 1'b0;
        check("lock_release_locked", {31'd0, bus.locked}, 32'd0);
        check("lock_release_ready",  {31'd0, bus.ready},  32'd1);
        check("lock_release_step",   {30'd0, bus.step},   32'd0);
        send_seq(8'b11_10_01_00, 0, 1'b1, 1'b0);

        // reset at lockout cycle 5 clears the lock and the fail count
        send_seq(8'b00_00_00_00, 0, 1'b0, 1'b0);
        send_seq(8'b00_00_00_00, 0, 1'b0, 1'b0);
        send_seq(8'b00_00_00_00, 0, 1'b0, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        check("lock_cycle5_locked", {31'd0, bus.locked}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("lock_rst_locked", {31'd0, bus.locked}, 32'd0);
        check("lock_rst_ready",  {31'd0, bus.ready},  32'd1);
        check("lock_rst_step",   {30'd0, bus.step},   32'd0);
        send_seq(8'b11_10_01_01, 0, 1'b0, 1'b0);
        send_seq(8'b11_10_01_01, 0, 1'b0, 1'b0);
        send_seq(8'b11_10_01_00, 0, 1'b1, 1'b0);
`else
        for (int n = 0; n < 5; n++) begin
            send_seq(8'b11_10_01_01, 1, 1'b0, 1'b0);
        end
        send_seq(8'b11_10_01_00, 0, 1'b1, 1'b0);
`endif

        repeat (3) begin @(posedge clk); #1; end
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
